test006: RTL and testbench

Self-checking compute block with a single `test` method behind a request/busy handshake. On request it fills an internal 16×32 array with squares of 0..9, sums them, and reports whether the sum equals 285. It is a standalone top-level method unit that a controller or simulation harness starts and polls.

---
 rtl/test006.sv | 111 +++++++++++
 tb/tb_test006.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/test006.sv
// rtl/test006.sv - self-checking sum-of-squares unit behind a request/busy handshake
// Fills a 16x32 array with i*i for i=0..9, sums it back out and flags sum==285.
module test006 (
  input  logic clk,
  input  logic reset,
  input  logic test_req,
  output logic test_busy,
  output logic test_return
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_READ,
    S_ACC,
    S_CHECK
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'd9;
  localparam logic [31:0] EXP_SUM  = 32'd285;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        ret_q, ret_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] sum_q, sum_d;

  logic [31:0] mem [16];
  logic [31:0] rdata_q;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [7:0]  sq;

  always_comb sq = {4'b0, idx_q} * {4'b0, idx_q};

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    ret_d     = ret_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    mem_we    = 1'b0;
    mem_wdata = {24'b0, sq};
    case (state_q)
      S_IDLE: begin
        if (test_req) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
        end
      end
      S_INIT: begin
        idx_d   = 4'd0;
        sum_d   = 32'd0;
        state_d = S_FILL;
      end
      S_FILL: begin
        mem_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = S_READ;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_READ: state_d = S_ACC;
      S_ACC: begin
        // rdata_q holds the word addressed during the preceding READ cycle
        sum_d = sum_q + rdata_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_READ;
        end
      end
      S_CHECK: begin
        ret_d   = (sum_q == EXP_SUM);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ret_q   <= 1'b0;
      idx_q   <= 4'd0;
      sum_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Array storage is deliberately unreset; every entry read is written earlier in the run.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= mem_wdata;
    rdata_q <= mem[idx_q];
  end

  assign test_busy   = busy_q;
  assign test_return = ret_q;

endmodule

// File: tb/tb_test006.sv
// tb/tb_test006.sv - scoreboard bench for test006
// Stimulus pushes expected run outcomes; a negedge monitor pops them when test_busy falls.
module tb_test006;

  logic clk = 1'b0;
  logic reset;
  logic test_req;
  logic test_busy;
  logic test_return;

  test006 dut (
    .clk(clk),
    .reset(reset),
    .test_req(test_req),
    .test_busy(test_busy),
    .test_return(test_return)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   len;
    logic ret;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   busy_cnt = 0;
  int   lo_cnt = 0;
  logic prev_busy = 1'b0;
  logic b2b_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int len, input logic ret);
    exp_t e;
    e.len = len;
    e.ret = ret;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (test_busy) begin
      if (!prev_busy && b2b_mode) check("b2b_gap", lo_cnt, 1);
      busy_cnt++;
      lo_cnt = 0;
    end else begin
      if (prev_busy) begin
        if (sb.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_run: got run of %0d busy cycles, expected none", busy_cnt);
        end else begin
          e = sb.pop_front();
          check("run_len", busy_cnt, e.len);
          check("run_return", int'(test_return), int'(e.ret));
        end
        busy_cnt = 0;
      end
      lo_cnt++;
    end
    prev_busy = test_busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    test_req = 1'b0;

    // held in reset: requests must not start anything
    for (int k = 0; k < 8; k++) begin
      tick();
      test_req = ~test_req;
      check("rst_busy", int'(test_busy), 0);
      check("rst_return", int'(test_return), 0);
    end
    tick();
    test_req = 1'b0;
    reset    = 1'b1;

    // back-to-back: three runs with req held high
    push(32, 1'b1);
    push(32, 1'b1);
    push(32, 1'b1);
    tick();
    test_req = 1'b1;
    repeat (10) tick();
    check("ret_before_first_check", int'(test_return), 0);
    b2b_mode = 1'b1;
    repeat (89) tick();
    test_req = 1'b0;
    b2b_mode = 1'b0;
    repeat (40) tick();
    check("b2b_idle_busy", int'(test_busy), 0);

    // single pulse
    push(32, 1'b1);
    tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (40) tick();
    check("single_idle_busy", int'(test_busy), 0);
    check("single_return_held", int'(test_return), 1);

    // extra requests at busy cycles 5 and 20 are ignored
    push(32, 1'b1);
    tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (4) tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (14) tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (40) tick();
    check("extra_idle_busy", int'(test_busy), 0);

    // asynchronous abort after 15 busy cycles
    push(15, 1'b0);
    tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (15) tick();
    reset = 1'b0;
    #1;
    check("abort_busy_async", int'(test_busy), 0);
    check("abort_return_async", int'(test_return), 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("post_abort_idle", int'(test_busy), 0);
    push(32, 1'b1);
    tick();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (40) tick();
    check("post_abort_return", int'(test_return), 1);

    // req dropped at busy cycle 2
    push(32, 1'b1);
    tick();
    test_req = 1'b1;
    repeat (2) tick();
    test_req = 1'b0;
    repeat (40) tick();
    check("drop_idle_busy", int'(test_busy), 0);
    check("drop_return", int'(test_return), 1);

    check("pending_runs", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
